// File: rtl/vr_pkg.sv
// vr_pkg: shared definitions for the valid/ready FIFO slice.
//   VR_DATA_W : default payload width
//   vr_data_t : payload type at the default width
//   is_pow2() : elaboration-time helper used to validate DEPTH
package vr_pkg;

   localparam int VR_DATA_W = 8;

   typedef logic [VR_DATA_W-1:0] vr_data_t;

   function automatic bit is_pow2(input int v);
      return (v > 0) && ((v & (v - 1)) == 0);
   endfunction

endpackage

// File: rtl/vr_fifo_mem.sv
// vr_fifo_mem: DEPTH x DATA_W register array for vr_fifo.
// Ports:
//   clk           : clock, write happens on the rising edge
//   we/waddr/wdata: synchronous write port
//   raddr/rdata   : asynchronous read port
// The array is deliberately not reset; the FIFO control never exposes
// an entry that has not been written since reset.
module vr_fifo_mem
   import vr_pkg::*;
#(
   parameter int DATA_W = VR_DATA_W,
   parameter int DEPTH  = 4,
   parameter int AW     = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              we,
   input  logic [AW-1:0]     waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [AW-1:0]     raddr,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/vr_fifo.sv
// vr_fifo: synchronous elastic FIFO with valid/ready on both sides.
// Ports:
//   clk, reset        : clock, synchronous active-high reset
//   s_valid/s_ready/s_data : upstream (write) handshake
//   m_valid/m_ready/m_data : downstream (read) handshake
//   level             : occupancy 0..DEPTH
// Optional build macro VR_FIFO_STATS_EN adds:
//   in_cnt, out_cnt   : 32-bit wrapping counts of accepted pushes/pops
//   max_level         : high-water mark of level
//
// Handshake: a word moves on a rising edge where valid && ready on that
// side. s_ready and m_valid depend only on registered state (and reset
// for s_ready), never on the opposite side's ready/valid, so a full FIFO
// refuses a push even when a pop happens in the same cycle, and an empty
// FIFO never bypasses s_data to m_data.
module vr_fifo
   import vr_pkg::*;
#(
   parameter int DATA_W = VR_DATA_W,
   parameter int DEPTH  = 4,
   parameter int CNT_W  = $clog2(DEPTH) + 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              s_valid,
   output logic              s_ready,
   input  logic [DATA_W-1:0] s_data,
   output logic              m_valid,
   input  logic              m_ready,
   output logic [DATA_W-1:0] m_data,
   output logic [CNT_W-1:0]  level
`ifdef VR_FIFO_STATS_EN
   ,
   output logic [31:0]       in_cnt,
   output logic [31:0]       out_cnt,
   output logic [CNT_W-1:0]  max_level
`endif
);

   localparam int AW = $clog2(DEPTH);

   if (!is_pow2(DEPTH) || DEPTH < 2) begin : g_bad_depth
      $error("vr_fifo: DEPTH must be a power of two and at least 2");
   end

   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          push;
   logic          pop;

   assign s_ready = !reset && (level != CNT_W'(DEPTH));
   assign m_valid = (level != '0);
   assign push    = s_valid && s_ready;
   assign pop     = m_valid && m_ready;

   // Pointers are exactly AW bits wide, so natural overflow is the
   // modulo-DEPTH wrap.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         case ({push, pop})
            2'b10:   level <= level + CNT_W'(1);
            2'b01:   level <= level - CNT_W'(1);
            default: level <= level;
         endcase
      end
   end

   vr_fifo_mem #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .AW     (AW)
   ) u_mem (
      .clk   (clk),
      .we    (push),
      .waddr (wr_ptr),
      .wdata (s_data),
      .raddr (rd_ptr),
      .rdata (m_data)
   );

`ifdef VR_FIFO_STATS_EN
   // max_level trails level by one cycle: it samples the registered level.
   always_ff @(posedge clk) begin
      if (reset) begin
         in_cnt    <= '0;
         out_cnt   <= '0;
         max_level <= '0;
      end else begin
         if (push) begin
            in_cnt <= in_cnt + 32'd1;
         end
         if (pop) begin
            out_cnt <= out_cnt + 32'd1;
         end
         if (level > max_level) begin
            max_level <= level;
         end
      end
   end
`endif

endmodule

// File: tb/tb_vr_fifo.sv
module tb_vr_fifo;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 4;
  localparam int CNT_W  = $clog2(DEPTH) + 1;

  logic              clk;
  logic              reset;
  logic              s_valid;
  logic              s_ready;
  logic [DATA_W-1:0] s_data;
  logic              m_valid;
  logic              m_ready;
  logic [DATA_W-1:0] m_data;
  logic [CNT_W-1:0]  level;
`ifdef VR_FIFO_STATS_EN
  logic [31:0]       in_cnt;
  logic [31:0]       out_cnt;
  logic [CNT_W-1:0]  max_level;
`endif

  int total = 0;
  int bad   = 0;

  logic [DATA_W-1:0] exp_q[$];
  int                pushes = 0;
  int                pops   = 0;

  vr_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_data    (s_data),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_data    (m_data),
    .level     (level)
`ifdef VR_FIFO_STATS_EN
    ,
    .in_cnt    (in_cnt),
    .out_cnt   (out_cnt),
    .max_level (max_level)
`endif
  );

  // clock / reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic              rst;
    logic              sv;
    logic [DATA_W-1:0] sd;
    logic              mr;
    logic              e_sready;
    logic              e_mvalid;
    logic [DATA_W-1:0] e_mdata;
    logic [CNT_W-1:0]  e_level;
  } vec_t;

  vec_t vecs[15];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic rst, input logic sv, input logic [DATA_W-1:0] sd, input logic mr);
    reset   = rst;
    s_valid = sv;
    s_data  = sd;
    m_ready = mr;
  endtask

  function automatic vec_t mk(input logic rst, input logic sv, input logic [7:0] sd, input logic mr,
                              input logic es, input logic em, input logic [7:0] ed, input int el);
    vec_t v;
    v.rst = rst; v.sv = sv; v.sd = sd; v.mr = mr;
    v.e_sready = es; v.e_mvalid = em; v.e_mdata = ed; v.e_level = CNT_W'(el);
    return v;
  endfunction

  initial begin
    // Each row: inputs applied this cycle; expectations are the outputs
    // seen before the edge that consumes those inputs.
    vecs[0]  = mk(1, 1, 8'h99, 0,  0, 0, 8'h00, 0);  // reset, source pushing
    vecs[1]  = mk(1, 1, 8'h99, 0,  0, 0, 8'h00, 0);
    vecs[2]  = mk(1, 1, 8'h99, 0,  0, 0, 8'h00, 0);
    vecs[3]  = mk(0, 1, 8'h11, 0,  1, 0, 8'h00, 0);  // fill
    vecs[4]  = mk(0, 1, 8'h22, 0,  1, 1, 8'h11, 1);
    vecs[5]  = mk(0, 1, 8'h33, 0,  1, 1, 8'h11, 2);
    vecs[6]  = mk(0, 1, 8'h44, 0,  1, 1, 8'h11, 3);
    vecs[7]  = mk(0, 1, 8'h55, 0,  0, 1, 8'h11, 4);  // full, 0x55 held
    vecs[8]  = mk(0, 1, 8'h55, 1,  0, 1, 8'h11, 4);  // full + pop: still not ready
    vecs[9]  = mk(0, 0, 8'h00, 1,  1, 1, 8'h22, 3);  // drain
    vecs[10] = mk(0, 0, 8'h00, 1,  1, 1, 8'h33, 2);
    vecs[11] = mk(0, 0, 8'h00, 1,  1, 1, 8'h44, 1);
    vecs[12] = mk(0, 1, 8'h55, 1,  1, 0, 8'h00, 0);  // empty: m_ready ignored, held 0x55 pushed
    vecs[13] = mk(0, 0, 8'h00, 1,  1, 1, 8'h55, 1);
    vecs[14] = mk(0, 0, 8'h00, 0,  1, 0, 8'h00, 0);

    void'($urandom(17));

    drive(1, 1, 8'h99, 0);
    next_cycle();

    // ---- table-driven reset / fill / drain ----
    for (int i = 0; i < 15; i++) begin
      drive(vecs[i].rst, vecs[i].sv, vecs[i].sd, vecs[i].mr);
      #1;
      check($sformatf("vec%0d s_ready", i), 32'(s_ready), 32'(vecs[i].e_sready));
      check($sformatf("vec%0d m_valid", i), 32'(m_valid), 32'(vecs[i].e_mvalid));
      check($sformatf("vec%0d level", i), 32'(level), 32'(vecs[i].e_level));
      if (vecs[i].e_mvalid)
        check($sformatf("vec%0d m_data", i), 32'(m_data), 32'(vecs[i].e_mdata));
`ifdef VR_FIFO_STATS_EN
      if (i == 12) begin
        check("stats in_cnt", in_cnt, 32'd4);
        check("stats out_cnt", out_cnt, 32'd4);
        check("stats max_level", 32'(max_level), 32'd4);
      end
`endif
      next_cycle();
    end

    // ---- streaming 0..99, both sides always ready ----
    for (int k = 0; k < 100; k++) begin
      drive(0, 1, DATA_W'(k), 1);
      #1;
      check("stream s_ready", 32'(s_ready), 32'd1);
      check("stream level", 32'(level), (k == 0) ? 32'd0 : 32'd1);
      check("stream m_valid", 32'(m_valid), (k == 0) ? 32'd0 : 32'd1);
      if (k != 0)
        check("stream m_data", 32'(m_data), 32'(k - 1));
      next_cycle();
    end
    drive(0, 0, 8'h00, 1);
    #1;
    check("stream last m_valid", 32'(m_valid), 32'd1);
    check("stream last m_data", 32'(m_data), 32'd99);
    next_cycle();
    check("stream end level", 32'(level), 32'd0);
    check("stream end m_valid", 32'(m_valid), 32'd0);
    m_ready = 1'b0;

    // ---- random stalls on both sides, scoreboarded ----
    fork
      begin : producer
        int  p_d;
        bit  p_acc;
        for (int w = 0; w < 100; w++) begin
          p_d = $urandom_range(0, 5);
          s_valid = 1'b0;
          repeat (p_d) next_cycle();
          s_valid = 1'b1;
          s_data  = DATA_W'($urandom_range(0, 255));
          p_acc   = 1'b0;
          for (int t = 0; t < 50 && !p_acc; t++) begin
            @(negedge clk);
            if (s_ready) begin
              p_acc = 1'b1;
              exp_q.push_back(s_data);
              pushes++;
            end
            next_cycle();
          end
          if (!p_acc) check("rand push timeout", 32'd0, 32'd1);
        end
        s_valid = 1'b0;
      end
      begin : consumer
        int  c_d;
        bit  c_got;
        for (int n = 0; n < 100; n++) begin
          c_d = $urandom_range(0, 5);
          m_ready = 1'b0;
          repeat (c_d) next_cycle();
          m_ready = 1'b1;
          c_got   = 1'b0;
          for (int t = 0; t < 200 && !c_got; t++) begin
            @(negedge clk);
            if (m_valid) begin
              c_got = 1'b1;
              pops++;
              if (exp_q.size() == 0)
                check("rand unexpected word", 32'(m_data), 32'hffff_ffff);
              else
                check("rand m_data", 32'(m_data), 32'(exp_q.pop_front()));
            end
            next_cycle();
          end
          if (!c_got) check("rand pop timeout", 32'd0, 32'd1);
        end
        m_ready = 1'b0;
      end
    join
    #1;
    check("rand pushes", pushes, 32'd100);
    check("rand pops", pops, 32'd100);
    check("rand queue empty", exp_q.size(), 32'd0);
    check("rand wraps>=20", 32'(pushes / DEPTH >= 20), 32'd1);
    check("rand end level", 32'(level), 32'd0);

    // ---- reset in the middle of operation ----
    drive(0, 1, 8'hc1, 0); next_cycle();
    drive(0, 1, 8'hc2, 0); next_cycle();
    drive(0, 1, 8'hc3, 0); next_cycle();
    drive(0, 0, 8'h00, 0);
    #1;
    check("midrst level before", 32'(level), 32'd3);
    drive(1, 1, 8'hee, 1);
    #1;
    check("midrst s_ready in reset", 32'(s_ready), 32'd0);
    next_cycle();
    drive(0, 1, 8'ha5, 0);
    #1;
    check("midrst level after", 32'(level), 32'd0);
    check("midrst m_valid after", 32'(m_valid), 32'd0);
    check("midrst s_ready after", 32'(s_ready), 32'd1);
    next_cycle();
    drive(0, 0, 8'h00, 0);
    #1;
    check("midrst first m_valid", 32'(m_valid), 32'd1);
    check("midrst first m_data", 32'(m_data), 32'ha5);
    check("midrst level one", 32'(level), 32'd1);
    m_ready = 1'b1;
    next_cycle();
    m_ready = 1'b0;
    #1;
    check("midrst drained", 32'(level), 32'd0);

    // final report
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
